// File: rtl/vga_poswh_receiver_pkg.sv
// Shared definitions for the position/width-height receiver: packed word
// field positions and the pending-word FSM states.
package vga_poswh_receiver_pkg;

  localparam int unsigned X_HI = 63;
  localparam int unsigned X_LO = 48;
  localparam int unsigned Y_HI = 47;
  localparam int unsigned Y_LO = 32;
  localparam int unsigned W_HI = 31;
  localparam int unsigned W_LO = 16;
  localparam int unsigned H_HI = 15;
  localparam int unsigned H_LO = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/vga_poswh_receiver_rect_hit_test.sv
// Combinational point-in-rectangle test. Right/bottom edges are formed
// 17 bits wide so a rectangle reaching 65535 never wraps.
module rect_hit_test (
  input  logic [15:0] px,
  input  logic [15:0] py,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] w,
  input  logic [15:0] h,
  output logic        hit
);

  logic [16:0] xEnd;
  logic [16:0] yEnd;

  always_comb begin
    xEnd = {1'b0, x} + {1'b0, w};
    yEnd = {1'b0, y} + {1'b0, h};
    // Zero width or height gives an empty half-open interval, so no hit.
    hit  = (px >= x) && ({1'b0, px} < xEnd) &&
           (py >= y) && ({1'b0, py} < yEnd);
  end

endmodule

// File: rtl/vga_poswh_receiver.sv
// Display-side receiver: holds one pending rectangle word, commits it at
// vsync_start, and registers the per-pixel inside-rectangle result.
module vga_poswh_receiver
  import vga_poswh_receiver_pkg::*;
#(
  parameter int unsigned COORD_W = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [63:0]        poswh_in,
  input  logic               poswh_valid,
  output logic               poswh_ready,
  input  logic               vsync_start,
  output logic               commit_done,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic               pix_valid,
  output logic               in_rect,
  output logic [15:0]        act_x,
  output logic [15:0]        act_y,
  output logic [15:0]        act_w,
  output logic [15:0]        act_h
);

  state_t      state;
  state_t      stateNext;
  logic [63:0] pending;
  logic        accept;
  logic        loadActive;
  logic        hitComb;

  assign poswh_ready = (state != FULL);
  assign accept      = poswh_valid && poswh_ready;

  always_comb begin
    stateNext   = state;
    commit_done = 1'b0;
    loadActive  = 1'b0;
    unique case (state)
      EMPTY: if (accept) stateNext = FULL;
      FULL: begin
        if (vsync_start) begin
          loadActive = 1'b1;
          stateNext  = DONE;
        end
      end
      DONE: begin
        commit_done = 1'b1;
        stateNext   = accept ? FULL : EMPTY;
      end
      default: stateNext = EMPTY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= EMPTY;
      pending <= '0;
    end else begin
      state <= stateNext;
      if (accept) pending <= poswh_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      act_x <= '0;
      act_y <= '0;
      act_w <= '0;
      act_h <= '0;
    end else if (loadActive) begin
      act_x <= pending[X_HI:X_LO];
      act_y <= pending[Y_HI:Y_LO];
      act_w <= pending[W_HI:W_LO];
      act_h <= pending[H_HI:H_LO];
    end
  end

  rect_hit_test uHit (
    .px (16'(pix_x)),
    .py (16'(pix_y)),
    .x  (act_x),
    .y  (act_y),
    .w  (act_w),
    .h  (act_h),
    .hit(hitComb)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) in_rect <= 1'b0;
    else       in_rect <= pix_valid && hitComb;
  end

endmodule

// File: tb/tb_vga_poswh_receiver.sv
// Directed bench for vga_poswh_receiver: FSM handshake/commit timing and a
// queue-based scoreboard for the one-cycle-delayed hit result.
module tb_vga_poswh_receiver;

  localparam int unsigned COORD_W = 10;

  logic               clock = 1'b0;
  logic               reset;
  logic [63:0]        poswh_in;
  logic               poswh_valid;
  logic               poswh_ready;
  logic               vsync_start;
  logic               commit_done;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               pix_valid;
  logic               in_rect;
  logic [15:0]        act_x, act_y, act_w, act_h;

  int nChecks = 0;
  int nErrors = 0;

  // Bench-side model of the active rectangle and pending hit expectations.
  int   mX = 0, mY = 0, mW = 0, mH = 0;
  logic hitQ[$];

  vga_poswh_receiver #(.COORD_W(COORD_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .poswh_in   (poswh_in),
    .poswh_valid(poswh_valid),
    .poswh_ready(poswh_ready),
    .vsync_start(vsync_start),
    .commit_done(commit_done),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_valid  (pix_valid),
    .in_rect    (in_rect),
    .act_x      (act_x),
    .act_y      (act_y),
    .act_w      (act_w),
    .act_h      (act_h)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic hitModel(input int px, input int py, input logic v);
    return v && (px >= mX) && (px < mX + mW) && (py >= mY) && (py < mY + mH);
  endfunction

  task automatic checkAct(input string tag, input int x, input int y, input int w, input int h);
    check({tag, "_x"}, 64'(act_x), 64'(x));
    check({tag, "_y"}, 64'(act_y), 64'(y));
    check({tag, "_w"}, 64'(act_w), 64'(w));
    check({tag, "_h"}, 64'(act_h), 64'(h));
  endtask

  // Present one pixel, expect its hit result after the next edge.
  task automatic pixel(input string tag, input int x, input int y, input logic v);
    logic exp;
    pix_x     = COORD_W'(x);
    pix_y     = COORD_W'(y);
    pix_valid = v;
    hitQ.push_back(hitModel(x, y, v));
    tick();
    exp = hitQ.pop_front();
    check(tag, 64'(in_rect), 64'(exp));
  endtask

  task automatic setModel(input int x, input int y, input int w, input int h);
    mX = x; mY = y; mW = w; mH = h;
  endtask

  initial begin
    reset       = 1'b1;
    poswh_in    = '0;
    poswh_valid = 1'b0;
    vsync_start = 1'b0;
    pix_x       = '0;
    pix_y       = '0;
    pix_valid   = 1'b0;

    // Reset state
    #2;
    check("rst_ready", 64'(poswh_ready), 64'd1);
    check("rst_commit", 64'(commit_done), 64'd0);
    check("rst_in_rect", 64'(in_rect), 64'd0);
    checkAct("rst_act", 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;

    // Basic accept and commit
    poswh_in    = {16'd100, 16'd50, 16'd20, 16'd10};
    poswh_valid = 1'b1;
    tick();
    poswh_valid = 1'b0;
    check("t1_ready_low", 64'(poswh_ready), 64'd0);
    checkAct("t1_act_hold", 0, 0, 0, 0);
    tick();
    check("t1_ready_still_low", 64'(poswh_ready), 64'd0);
    check("t1_no_commit", 64'(commit_done), 64'd0);
    vsync_start = 1'b1;
    tick();
    vsync_start = 1'b0;
    setModel(100, 50, 20, 10);
    checkAct("t1_act", 100, 50, 20, 10);
    check("t1_commit", 64'(commit_done), 64'd1);
    check("t1_ready_done", 64'(poswh_ready), 64'd1);
    tick();
    check("t1_commit_one_cycle", 64'(commit_done), 64'd0);
    check("t1_ready_empty", 64'(poswh_ready), 64'd1);

    // Hit sweep across the horizontal edges
    for (int x = 98; x <= 121; x++) pixel($sformatf("sweep_x%0d", x), x, 55, 1'b1);
    pixel("row_bottom_out", 105, 60, 1'b1);
    pixel("row_top_in", 105, 50, 1'b1);
    pixel("row_last_in", 119, 59, 1'b1);
    pixel("pix_invalid", 105, 55, 1'b0);
    pix_valid = 1'b0;

    // Second word stalls while FULL, captured during DONE
    poswh_in    = {16'd10, 16'd20, 16'd30, 16'd40};
    poswh_valid = 1'b1;
    tick();
    poswh_in = {16'd200, 16'd0, 16'd5, 16'd5};
    tick();
    check("t3_stall_ready", 64'(poswh_ready), 64'd0);
    tick();
    check("t3_stall_ready2", 64'(poswh_ready), 64'd0);
    checkAct("t3_act_old", 100, 50, 20, 10);
    vsync_start = 1'b1;
    tick();
    vsync_start = 1'b0;
    checkAct("t3_first_commit", 10, 20, 30, 40);
    check("t3_commit", 64'(commit_done), 64'd1);
    check("t3_ready_done", 64'(poswh_ready), 64'd1);
    tick();
    poswh_valid = 1'b0;
    check("t3_second_taken", 64'(poswh_ready), 64'd0);
    check("t3_commit_clear", 64'(commit_done), 64'd0);
    checkAct("t3_first_unchanged", 10, 20, 30, 40);
    vsync_start = 1'b1;
    tick();
    vsync_start = 1'b0;
    checkAct("t3_second_commit", 200, 0, 5, 5);
    check("t3_commit2", 64'(commit_done), 64'd1);
    tick();

    // Accept and vsync in the same EMPTY cycle
    poswh_in    = {16'd0, 16'd0, 16'd640, 16'd480};
    poswh_valid = 1'b1;
    vsync_start = 1'b1;
    tick();
    poswh_valid = 1'b0;
    vsync_start = 1'b0;
    check("t4_full", 64'(poswh_ready), 64'd0);
    check("t4_no_commit", 64'(commit_done), 64'd0);
    checkAct("t4_act_old", 200, 0, 5, 5);
    tick();
    check("t4_no_commit2", 64'(commit_done), 64'd0);
    vsync_start = 1'b1;
    tick();
    vsync_start = 1'b0;
    setModel(0, 0, 640, 480);
    checkAct("t4_act", 0, 0, 640, 480);
    check("t4_commit", 64'(commit_done), 64'd1);
    tick();
    pixel("t4_corner_in", 639, 479, 1'b1);
    pixel("t4_right_out", 640, 0, 1'b1);
    pixel("t4_bottom_out", 0, 480, 1'b1);
    pixel("t4_origin_in", 0, 0, 1'b1);
    pix_valid = 1'b0;

    // Far-right rectangle and zero width
    poswh_in    = {16'd65530, 16'd0, 16'd20, 16'd1};
    poswh_valid = 1'b1;
    tick();
    poswh_valid = 1'b0;
    vsync_start = 1'b1;
    tick();
    vsync_start = 1'b0;
    setModel(65530, 0, 20, 1);
    checkAct("t5_act", 65530, 0, 20, 1);
    tick();
    pixel("t5_x1023", 1023, 0, 1'b1);
    pixel("t5_x0", 0, 0, 1'b1);
    pix_valid   = 1'b0;
    poswh_in    = {16'd0, 16'd0, 16'd0, 16'd10};
    poswh_valid = 1'b1;
    tick();
    poswh_valid = 1'b0;
    vsync_start = 1'b1;
    tick();
    vsync_start = 1'b0;
    setModel(0, 0, 0, 10);
    tick();
    pixel("t5_w0_origin", 0, 0, 1'b1);
    pixel("t5_w0_inner", 0, 5, 1'b1);
    pix_valid = 1'b0;

    // Re-establish a hitting rectangle, then reset mid-FULL
    poswh_in    = {16'd0, 16'd0, 16'd640, 16'd480};
    poswh_valid = 1'b1;
    tick();
    poswh_valid = 1'b0;
    vsync_start = 1'b1;
    tick();
    vsync_start = 1'b0;
    setModel(0, 0, 640, 480);
    tick();
    poswh_in    = {16'd300, 16'd300, 16'd50, 16'd50};
    poswh_valid = 1'b1;
    pixel("t6_hit_before_reset", 5, 5, 1'b1);
    poswh_valid = 1'b0;
    check("t6_full", 64'(poswh_ready), 64'd0);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_ready", 64'(poswh_ready), 64'd1);
    check("t6_async_in_rect", 64'(in_rect), 64'd0);
    check("t6_async_commit", 64'(commit_done), 64'd0);
    checkAct("t6_async_act", 0, 0, 0, 0);
    pix_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    setModel(0, 0, 0, 0);
    vsync_start = 1'b1;
    tick();
    vsync_start = 1'b0;
    check("t6_no_commit", 64'(commit_done), 64'd0);
    checkAct("t6_act_zero", 0, 0, 0, 0);
    tick();
    check("t6_no_commit2", 64'(commit_done), 64'd0);
    pixel("t6_no_hit", 5, 5, 1'b1);
    pix_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
